// File: rtl/mem_arbiter.sv
// Two-master arbiter for the shared single-port program/data RAM.
// Master 0 is the CPU memory port, master 1 the DMA/peripheral engine.
// Accesses are serialised through IDLE -> ACCESS -> ACK with a fixed
// read latency; collisions resolve round-robin or fixed-priority.
module mem_arbiter #(
  parameter int unsigned AW        = 16,
  parameter int unsigned DW        = 16,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_ce,
  input  logic          i_req0,
  input  logic          i_we0,
  input  logic [AW-1:0] i_addr0,
  input  logic [DW-1:0] i_wdata0,
  output logic          o_ack0,
  input  logic          i_req1,
  input  logic          i_we1,
  input  logic [AW-1:0] i_addr1,
  input  logic [DW-1:0] i_wdata1,
  output logic          o_ack1,
  output logic [DW-1:0] o_rdata,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  output logic          o_mem_we,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_busy,
  output logic          o_owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [2:0]    lat_q, lat_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          own_we;
  logic [AW-1:0] own_addr;
  logic [DW-1:0] own_wdata;
  logic          any_req;
  logic          winner;

  // Request fields are taken live from whichever master currently owns the RAM.
  always_comb begin
    own_we    = owner_q ? i_we1    : i_we0;
    own_addr  = owner_q ? i_addr1  : i_addr0;
    own_wdata = owner_q ? i_wdata1 : i_wdata0;
  end

  // Winner selection: a lone requester wins; on a tie the mode decides.
  always_comb begin
    any_req = i_req0 | i_req1;
    if (i_req0 && i_req1) begin
      if (PRIO_MODE == 1) winner = 1'b0;
      else                winner = ~last_q;
    end else begin
      winner = ~i_req0;
    end
  end

  // State register; reset overrides the clock enable.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      lat_q   <= '0;
      rdata_q <= '0;
    end else if (i_ce) begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      lat_q   <= lat_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic and RAM/handshake outputs, all decoded from the current state.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    lat_d       = lat_q;
    rdata_d     = rdata_q;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_we    = 1'b0;
    o_ack0      = 1'b0;
    o_ack1      = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d = winner;
          last_d  = winner;
          lat_d   = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        o_mem_addr  = own_addr;
        o_mem_wdata = own_wdata;
        if (own_we) begin
          o_mem_we = 1'b1;
          state_d  = ACK;
        end else if (lat_q == LAT_LAST) begin
          rdata_d = i_mem_rdata;
          state_d = ACK;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      ACK: begin
        o_mem_addr  = own_addr;
        o_mem_wdata = own_wdata;
        o_ack0      = ~owner_q;
        o_ack1      = owner_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_busy  = (state_q != IDLE);
  assign o_owner = owner_q;
  assign o_rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances (round-robin RD_LAT=1,
// fixed-priority RD_LAT=1, round-robin RD_LAT=3) share one stimulus set,
// each phase resets them and checks the instance selected by 'sel'.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n, ce;
  logic        req0, we0, req1, we1;
  logic [15:0] addr0, wdata0, addr1, wdata1;

  logic [2:0]  ack0, ack1, mem_we, busy, owner;
  logic [15:0] rdata     [3];
  logic [15:0] mem_addr  [3];
  logic [15:0] mem_wdata [3];
  logic [15:0] mem_rdata [3];

  typedef struct {
    logic        m;
    logic        rd;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  int sel     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned LAT = (g == 2) ? 3 : 1;
    localparam int unsigned PM  = (g == 1) ? 1 : 0;
    logic [15:0] mem [256];

    mem_arbiter #(.AW(16), .DW(16), .RD_LAT(LAT), .PRIO_MODE(PM)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce),
      .i_req0(req0), .i_we0(we0), .i_addr0(addr0), .i_wdata0(wdata0), .o_ack0(ack0[g]),
      .i_req1(req1), .i_we1(we1), .i_addr1(addr1), .i_wdata1(wdata1), .o_ack1(ack1[g]),
      .o_rdata(rdata[g]), .o_mem_addr(mem_addr[g]), .o_mem_wdata(mem_wdata[g]),
      .o_mem_we(mem_we[g]), .i_mem_rdata(mem_rdata[g]), .o_busy(busy[g]), .o_owner(owner[g])
    );

    // RAM model shares the clock enable with the arbiter.
    assign mem_rdata[g] = mem[mem_addr[g][7:0]];
    always @(posedge clk) if (ce && mem_we[g]) mem[mem_addr[g][7:0]] <= mem_wdata[g];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample 2 time units later, and score any ack.
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #2;
    if (ack0[sel] || ack1[sel]) begin
      check("ack_onehot", {31'b0, ack0[sel] & ack1[sel]}, 0);
      if (sb.size() == 0) begin
        check("ack_unexpected", {30'b0, ack1[sel], ack0[sel]}, 0);
      end else begin
        e = sb.pop_front();
        check("ack_master", {31'b0, ack1[sel]}, {31'b0, e.m});
        if (e.rd) check("rdata", {16'b0, rdata[sel]}, {16'b0, e.data});
      end
    end
  endtask

  task automatic push(input logic m, input logic rd, input logic [15:0] data);
    exp_t e;
    e.m = m; e.rd = rd; e.data = data;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    ce = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

    // Reset state
    sel = 0;
    do_reset();
    check("rst_ack",   {30'b0, ack1[0], ack0[0]}, 0);
    check("rst_we",    {31'b0, mem_we[0]}, 0);
    check("rst_addr",  {16'b0, mem_addr[0]}, 0);
    check("rst_wdata", {16'b0, mem_wdata[0]}, 0);
    check("rst_busy",  {31'b0, busy[0]}, 0);
    check("rst_owner", {31'b0, owner[0]}, 0);
    check("rst_rdata", {16'b0, rdata[0]}, 0);

    // Master 0 writes 0x1234 to 0x0040
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0040; wdata0 = 16'h1234;
    push(1'b0, 1'b0, 16'h0);
    cyc();
    check("wr_we",    {31'b0, mem_we[0]}, 1);
    check("wr_addr",  {16'b0, mem_addr[0]}, 32'h0040);
    check("wr_wdata", {16'b0, mem_wdata[0]}, 32'h1234);
    check("wr_busy",  {31'b0, busy[0]}, 1);
    check("wr_noack", {31'b0, ack0[0]}, 0);
    cyc();
    check("wr_ack",   {30'b0, ack1[0], ack0[0]}, 32'b01);
    check("wr_we_off", {31'b0, mem_we[0]}, 0);
    req0 = 1'b0;
    cyc();
    check("wr_idle_busy", {31'b0, busy[0]}, 0);
    check("wr_idle_we",   {31'b0, mem_we[0]}, 0);

    // Master 1 reads 0x0040 back
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0040;
    push(1'b1, 1'b1, 16'h1234);
    cyc();
    check("rd_owner", {31'b0, owner[0]}, 1);
    check("rd_we",    {31'b0, mem_we[0]}, 0);
    check("rd_addr",  {16'b0, mem_addr[0]}, 32'h0040);
    cyc();
    check("rd_ack",   {30'b0, ack1[0], ack0[0]}, 32'b10);
    check("rd_data",  {16'b0, rdata[0]}, 32'h1234);
    req1 = 1'b0;
    cyc();
    check("rd_idle_busy", {31'b0, busy[0]}, 0);
    check("rd_hold",      {16'b0, rdata[0]}, 32'h1234);

    // Continuous requests, round-robin: grants alternate 0,1,0,1
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0010; wdata0 = 16'hA0A0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0020; wdata1 = 16'hB1B1;
    for (int t = 0; t < 4; t++) begin
      push(1'(t % 2), 1'b0, 16'h0);
      cyc();
      check("rr_owner", {31'b0, owner[0]}, t % 2);
      check("rr_addr",  {16'b0, mem_addr[0]}, (t % 2) ? 32'h0020 : 32'h0010);
      cyc();
      check("rr_ack",   {30'b0, ack1[0], ack0[0]}, (t % 2) ? 32'b10 : 32'b01);
      if (t == 3) begin req0 = 1'b0; req1 = 1'b0; end
      cyc();
      check("rr_turnaround", {31'b0, busy[0]}, 0);
    end

    // Continuous requests, fixed priority: master 0 always wins
    sel = 1;
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    for (int t = 0; t < 4; t++) begin
      push(1'b0, 1'b0, 16'h0);
      cyc();
      check("fp_owner", {31'b0, owner[1]}, 0);
      cyc();
      check("fp_ack",   {30'b0, ack1[1], ack0[1]}, 32'b01);
      if (t == 3) begin req0 = 1'b0; req1 = 1'b0; end
      cyc();
      check("fp_no_ack1", {31'b0, ack1[1]}, 0);
    end

    // RD_LAT=3 read with i_ce low for 3 cycles during ACCESS
    sel = 2;
    do_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0055; wdata0 = 16'hBEEF;
    push(1'b0, 1'b0, 16'h0);
    cyc(); cyc();
    req0 = 1'b0;
    cyc();
    req0 = 1'b1; we0 = 1'b0;
    push(1'b0, 1'b1, 16'hBEEF);
    cyc();
    check("ce_busy",  {31'b0, busy[2]}, 1);
    check("ce_we",    {31'b0, mem_we[2]}, 0);
    cyc();
    check("ce_c2",    {31'b0, ack0[2]}, 0);
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("ce_frozen_ack",  {31'b0, ack0[2]}, 0);
      check("ce_frozen_busy", {31'b0, busy[2]}, 1);
    end
    ce = 1'b1;
    cyc();
    check("ce_c6", {31'b0, ack0[2]}, 0);
    cyc();
    check("ce_ack", {31'b0, ack0[2]}, 1);
    check("ce_rdata", {16'b0, rdata[2]}, 32'hBEEF);
    req0 = 1'b0;
    cyc();
    check("ce_idle", {31'b0, busy[2]}, 0);

    // Reset pulsed during a read ACCESS abandons it
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0055;
    cyc();
    check("ra_owner", {31'b0, owner[2]}, 1);
    cyc();
    rst_n = 1'b0;
    cyc();
    check("ra_ack",   {30'b0, ack1[2], ack0[2]}, 0);
    check("ra_we",    {31'b0, mem_we[2]}, 0);
    check("ra_busy",  {31'b0, busy[2]}, 0);
    check("ra_rdata", {16'b0, rdata[2]}, 0);
    check("ra_owner0", {31'b0, owner[2]}, 0);
    rst_n = 1'b1; req1 = 1'b0;
    cyc();
    check("ra_idle", {31'b0, busy[2]}, 0);
    req1 = 1'b1;
    push(1'b1, 1'b1, 16'hBEEF);
    cyc();
    check("ra_regrant", {31'b0, owner[2]}, 1);
    check("ra_regrant_busy", {31'b0, busy[2]}, 1);
    cyc(); cyc(); cyc();
    check("ra_ack1", {31'b0, ack1[2]}, 1);
    req1 = 1'b0;
    cyc();

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master arbiter sharing the single-port synchronous program/data RAM.
- Master 0 is the CPU memory port; master 1 is a DMA/peripheral engine.
- Serialises accesses with a req/ack handshake, fixes read latency, and picks a winner on collisions (round-robin or fixed priority).
- Sits between the masters and the RAM; owns o_mem_addr, o_mem_wdata and o_mem_we.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- RD_LAT, 1, RAM read latency in cycles (legal range 1-7).
- PRIO_MODE, 0, arbitration mode: 0 = round-robin; 1 = fixed priority, master 0 wins.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_ce  in  1  clock enable; state, counters and registers advance only when 1.
- i_req0  in  1  master 0 request; held with we/addr/wdata stable until o_ack0.
- i_we0  in  1  master 0 write (1) / read (0).
- i_addr0  in  AW  master 0 address.
- i_wdata0  in  DW  master 0 write data.
- o_ack0  out  1  one-cycle completion pulse to master 0.
- i_req1, i_we1, i_addr1, i_wdata1, o_ack1: same roles for master 1.
- o_rdata  out  DW  read data register; valid in the o_ackN cycle, held until next read capture.
- o_mem_addr  out  AW  RAM address.
- o_mem_wdata  out  DW  RAM write data.
- o_mem_we  out  1  RAM write enable.
- i_mem_rdata  in  DW  RAM read data, valid RD_LAT cycles after address presented.
- o_busy  out  1  1 in any state other than IDLE.
- o_owner  out  1  currently/last granted master index.

Behaviour:
- States: IDLE, ACCESS, ACK. Registers: state, owner, last_grant, lat_cnt (3 bits), rdata.
- Reset (i_rst_n=0 at an edge, overrides i_ce):
  - state=IDLE, owner=0, last_grant=1 (master 0 wins the first tie), lat_cnt=0, rdata=0.
  - All outputs combinational from state: after the reset edge, o_ack0=o_ack1=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_busy=0, o_owner=0.
  - Reset mid-ACCESS abandons the transaction with no ack; a write in flight is cut after the current cycle.
- IDLE:
  - RAM outputs are 0.
  - Only i_req0 high: grant master 0. Only i_req1 high: grant master 1.
  - Both high, PRIO_MODE=0: grant the master != last_grant. PRIO_MODE=1: grant master 0.
  - On grant: owner<=winner, last_grant<=winner, lat_cnt<=0, state<=ACCESS. No request: stay IDLE.
- ACCESS:
  - o_mem_addr=addr[owner]; o_mem_wdata=wdata[owner].
  - Write: o_mem_we=1 for exactly one cycle, then state<=ACK.
  - Read: o_mem_we=0; stay RD_LAT cycles with lat_cnt incrementing. On the edge where lat_cnt==RD_LAT-1: rdata<=i_mem_rdata, state<=ACK.
  - i_we/addr/wdata are sampled live from the owner. A master changing them mid-transaction is a protocol violation; the result is undefined but the FSM still completes.
- ACK:
  - o_ack[owner]=1 for exactly one cycle; o_mem_addr is still driven and o_mem_we=0.
  - Next edge: state<=IDLE.
  - The master must drop req on the edge that samples ack; IDLE ignores nothing, so a held req starts a new transaction.
- Latency from the req-sampling edge: write ack in cycle 2, read ack in cycle 1+RD_LAT. One mandatory IDLE turnaround cycle between transactions.
- Dropping req during ACCESS/ACK does not abort; ack still pulses.
- i_ce=0: all registers freeze; combinational outputs hold their values. o_mem_we stays high if frozen in a write ACCESS, so the RAM must share i_ce.
- o_ack0 and o_ack1 are never high together. o_mem_we is never high outside ACCESS.
- Under continuous requests from both masters in round-robin mode, grants strictly alternate; no starvation.

Test Plan:
- Reset, then master 0 writes 0x1234 to 0x0040 -> o_mem_we=1 exactly one cycle with addr 0x0040 and wdata 0x1234; o_ack0 two cycles after the req edge; o_busy then drops.
- Master 1 reads 0x0040 with RD_LAT=1 -> o_rdata=0x1234 and o_ack1 in the same cycle, 2 cycles after the req edge; o_ack0 stays 0.
- Both masters request continuously, PRIO_MODE=0 -> grant order 0,1,0,1 across 4 transactions; each ack one-hot.
- Same stimulus with PRIO_MODE=1 and master 0 never dropping req -> master 1 never acked; o_owner stays 0.
- i_ce held low 3 cycles during a read ACCESS with RD_LAT=3 -> ack delayed by exactly 3 cycles; o_rdata is correct.
- i_rst_n pulsed low during a read ACCESS -> no ack; o_mem_we=0, o_busy=0 and o_rdata=0 after the edge; the next request is granted normally.
